// File: rtl/sun_bank_arbiter_pkg.sv
// Shared PvZ game types: sun width, FSM states,
// requester IDs, plant costs and round-robin pick.
package pvz_pkg;

  localparam int SUN_W = 16;

  localparam logic [SUN_W-1:0] PEASHOOTER = 16'd100;
  localparam logic [SUN_W-1:0] SUNFLOWER  = 16'd50;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_COMMIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    REQ_DRIP    = 2'd0,
    REQ_COLLECT = 2'd1,
    REQ_BUY     = 2'd2
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } pick_t;

  function automatic req_id_e rr_next(input req_id_e id);
    unique case (id)
      REQ_DRIP:    return REQ_COLLECT;
      REQ_COLLECT: return REQ_BUY;
      default:     return REQ_DRIP;
    endcase
  endfunction

  // Scan from ptr downwards in reverse so the
  // requester closest to ptr is written last.
  function automatic pick_t rr_pick(
    input logic [2:0] req,
    input req_id_e    ptr
  );
    pick_t      p;
    logic [1:0] k;
    p.valid = 1'b0;
    p.id    = REQ_DRIP;
    for (int i = 2; i >= 0; i--) begin
      k = 2'((int'(ptr) + i) % 3);
      if (req[k]) begin
        p.valid = 1'b1;
        p.id    = req_id_e'(k);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sun_bank_arbiter_if.sv
// Game-logic <-> sun bank bus: requests,
// completion pulses and the displayed balance.
interface sun_bank_arbiter_if;
  import pvz_pkg::*;

  logic             game_clear;
  logic             enable;
  logic             collect_req;
  logic             collect_ack;
  logic             buy_req;
  logic [SUN_W-1:0] buy_cost;
  logic             buy_ack;
  logic             buy_grant;
  logic [SUN_W-1:0] num_suns;
  logic             busy;

  modport master (
    output game_clear, enable,
    output collect_req, buy_req, buy_cost,
    input  collect_ack, buy_ack, buy_grant,
    input  num_suns, busy
  );

  modport slave (
    input  game_clear, enable,
    input  collect_req, buy_req, buy_cost,
    output collect_ack, buy_ack, buy_grant,
    output num_suns, busy
  );

endinterface

// File: rtl/sun_bank_arbiter_drip.sv
// Periodic sun drip: free-running while enabled,
// raises one coalesced pending flag per expiry.
module drip_timer #(
  parameter int unsigned PERIOD = 500_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic consume,
  output logic pending
);

  localparam int CW =
    (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          expire;

  // Count while enabled; a fresh expiry beats consume.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    pend_d = (pend_q & ~consume) | expire;
    if (clear) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end
  end

  // Timer and pending flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/sun_bank_arbiter.sv
// Sun balance owner: round-robin arbitration of
// drip, collect and buy, saturating arithmetic.
module sun_bank_arbiter
  import pvz_pkg::*;
#(
  parameter int unsigned INIT_SUNS      = 50,
  parameter int unsigned MAX_SUNS       = 9990,
  parameter int unsigned DRIP_PERIOD    = 500_000_000,
  parameter int unsigned DRIP_AMOUNT    = 25,
  parameter int unsigned COLLECT_AMOUNT = 25
) (
  input logic         clk,
  input logic         rst_n,
  sun_bank_arbiter_if.slave bus
);

  localparam logic [SUN_W-1:0] INIT_V =
    SUN_W'(INIT_SUNS);
  localparam logic [SUN_W:0] MAX_V =
    (SUN_W+1)'(MAX_SUNS);
  localparam logic [SUN_W:0] DRIP_V =
    (SUN_W+1)'(DRIP_AMOUNT);
  localparam logic [SUN_W:0] COLL_V =
    (SUN_W+1)'(COLLECT_AMOUNT);

  state_e           state_q, state_d;
  req_id_e          win_q, win_d;
  req_id_e          ptr_q, ptr_d;
  logic [SUN_W-1:0] cost_q, cost_d;
  logic [SUN_W-1:0] suns_q, suns_d;
  logic             cack_q, cack_d;
  logic             back_q, back_d;
  logic             grant_q, grant_d;
  logic             busy_q, busy_d;

  logic             drip_pend;
  logic             consume;
  logic [2:0]       reqs;
  pick_t            pick;
  logic [SUN_W:0]   sum;

  assign consume = (state_q == S_COMMIT) &&
                   (win_q == REQ_DRIP);

  drip_timer #(.PERIOD(DRIP_PERIOD)) u_drip (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.game_clear),
    .enable  (bus.enable),
    .consume (consume),
    .pending (drip_pend)
  );

  // A requester being acked this cycle sits out.
  assign reqs = {bus.buy_req & ~back_q,
                 bus.collect_req & ~cack_q,
                 drip_pend};
  assign pick = rr_pick(reqs, ptr_q);
  assign sum  = {1'b0, suns_q} +
                ((win_q == REQ_DRIP) ? DRIP_V : COLL_V);

  // Arbitrate in IDLE, apply the operation in COMMIT.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    cost_d  = cost_q;
    suns_d  = suns_q;
    cack_d  = 1'b0;
    back_d  = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick.valid) begin
          win_d   = pick.id;
          ptr_d   = rr_next(pick.id);
          cost_d  = bus.buy_cost;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (win_q == REQ_BUY) begin
          back_d = 1'b1;
          if (suns_q >= cost_q) begin
            suns_d  = suns_q - cost_q;
            grant_d = 1'b1;
          end
        end else begin
          suns_d = (sum > MAX_V) ? MAX_V[SUN_W-1:0]
                                 : sum[SUN_W-1:0];
          cack_d = (win_q == REQ_COLLECT);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.game_clear) begin
      state_d = S_IDLE;
      ptr_d   = REQ_DRIP;
      suns_d  = INIT_V;
      cack_d  = 1'b0;
      back_d  = 1'b0;
      grant_d = 1'b0;
    end
    busy_d = (state_d == S_COMMIT);
  end

  // FSM, balance and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= REQ_DRIP;
      ptr_q   <= REQ_DRIP;
      cost_q  <= '0;
      suns_q  <= INIT_V;
      cack_q  <= 1'b0;
      back_q  <= 1'b0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cost_q  <= cost_d;
      suns_q  <= suns_d;
      cack_q  <= cack_d;
      back_q  <= back_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.num_suns    = suns_q;
  assign bus.collect_ack = cack_q;
  assign bus.buy_ack     = back_q;
  assign bus.buy_grant   = grant_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_sun_bank_arbiter.sv
// Directed bench for sun_bank_arbiter
// with a short drip period.
module tb_sun_bank_arbiter;
  import pvz_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sun_bank_arbiter_if bus();

  sun_bank_arbiter #(.DRIP_PERIOD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit is_buy,
                        input logic [15:0] cost,
                        output int lat,
                        output bit grant);
    bit got;
    got   = 1'b0;
    lat   = 0;
    grant = 1'b0;
    if (is_buy) begin
      bus.buy_cost = cost;
      bus.buy_req  = 1'b1;
    end else begin
      bus.collect_req = 1'b1;
    end
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (is_buy ? bus.buy_ack : bus.collect_ack) begin
        got   = 1'b1;
        grant = bus.buy_grant;
      end
    end
    if (!got) lat = 99;
    bus.buy_req     = 1'b0;
    bus.collect_req = 1'b0;
    tick();
  endtask

  task automatic do_clear(input bit en);
    bus.game_clear = 1'b1;
    bus.enable     = 1'b0;
    tick();
    bus.game_clear = 1'b0;
    bus.enable     = en;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    total++;
    if (bus.num_suns !== 16'd50) begin
      bad++;
      $display("FAIL rst_suns: got %0d want 50",
               bus.num_suns);
    end
    total++;
    if ({bus.collect_ack, bus.buy_ack,
         bus.buy_grant, bus.busy} !== 4'b0) begin
      bad++;
      $display("FAIL rst_flags: got %b want 0000",
               {bus.collect_ack, bus.buy_ack,
                bus.buy_grant, bus.busy});
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.num_suns !== 16'd50 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_release: got %0d/%b want 50/0",
               bus.num_suns, bus.busy);
    end
  endtask

  task automatic test_collect;
    bus.collect_req = 1'b1;
    tick();
    total++;
    if (bus.busy !== 1'b1 || bus.collect_ack !== 1'b0 ||
        bus.num_suns !== 16'd50) begin
      bad++;
      $display("FAIL coll_arb: got b%b a%b %0d want 1 0 50",
               bus.busy, bus.collect_ack, bus.num_suns);
    end
    tick();
    bus.collect_req = 1'b0;
    total++;
    if (bus.collect_ack !== 1'b1 ||
        bus.num_suns !== 16'd75) begin
      bad++;
      $display("FAIL coll_commit: got a%b %0d want 1 75",
               bus.collect_ack, bus.num_suns);
    end
    tick();
    total++;
    if (bus.collect_ack !== 1'b0 ||
        bus.num_suns !== 16'd75) begin
      bad++;
      $display("FAIL coll_pulse: got a%b %0d want 0 75",
               bus.collect_ack, bus.num_suns);
    end
  endtask

  task automatic test_buy;
    int lat;
    bit g;
    run_op(1'b1, PEASHOOTER, lat, g);
    total++;
    if (lat != 2 || g !== 1'b0 ||
        bus.num_suns !== 16'd75) begin
      bad++;
      $display("FAIL buy_deny: got l%0d g%b %0d want 2 0 75",
               lat, g, bus.num_suns);
    end
    run_op(1'b1, SUNFLOWER, lat, g);
    total++;
    if (lat != 2 || g !== 1'b1 ||
        bus.num_suns !== 16'd25) begin
      bad++;
      $display("FAIL buy_ok: got l%0d g%b %0d want 2 1 25",
               lat, g, bus.num_suns);
    end
  endtask

  task automatic test_saturate;
    int lat;
    bit g;
    for (int i = 0; i < 398; i++) begin
      run_op(1'b0, 16'd0, lat, g);
      total++;
      if (lat != 2) begin
        bad++;
        $display("FAIL fill_lat: got %0d want 2", lat);
      end
    end
    total++;
    if (bus.num_suns !== 16'd9975) begin
      bad++;
      $display("FAIL fill: got %0d want 9975", bus.num_suns);
    end
    run_op(1'b0, 16'd0, lat, g);
    total++;
    if (bus.num_suns !== 16'd9990) begin
      bad++;
      $display("FAIL clamp1: got %0d want 9990", bus.num_suns);
    end
    run_op(1'b1, 16'd10, lat, g);
    total++;
    if (g !== 1'b1 || bus.num_suns !== 16'd9980) begin
      bad++;
      $display("FAIL buy10: got g%b %0d want 1 9980",
               g, bus.num_suns);
    end
    run_op(1'b0, 16'd0, lat, g);
    total++;
    if (bus.num_suns !== 16'd9990) begin
      bad++;
      $display("FAIL sat_add: got %0d want 9990", bus.num_suns);
    end
    run_op(1'b0, 16'd0, lat, g);
    total++;
    if (lat != 2 || bus.num_suns !== 16'd9990) begin
      bad++;
      $display("FAIL sat_hold: got l%0d %0d want 2 9990",
               lat, bus.num_suns);
    end
  endtask

  task automatic test_rotation;
    int last_c, last_b, drips, kind, prev_kind;
    logic [15:0] prev;
    bus.collect_req = 1'b1;
    bus.buy_req     = 1'b1;
    bus.buy_cost    = 16'd0;
    do_clear(1'b1);
    total++;
    if (bus.num_suns !== 16'd50) begin
      bad++;
      $display("FAIL rot_clear: got %0d want 50", bus.num_suns);
    end
    prev      = bus.num_suns;
    last_c    = 0;
    last_b    = 0;
    drips     = 0;
    prev_kind = -1;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      tick();
      kind = -1;
      if (bus.collect_ack) kind = 1;
      else if (bus.buy_ack) kind = 2;
      else if (bus.num_suns > prev) kind = 0;
      if (kind == 0) drips++;
      if (kind == 1) begin
        total++;
        if (cyc - last_c > 6) begin
          bad++;
          $display("FAIL rot_cwait: got %0d want <=6",
                   cyc - last_c);
        end
        last_c = cyc;
      end
      if (kind == 2) begin
        total++;
        if (cyc - last_b > 6 || bus.buy_grant !== 1'b1) begin
          bad++;
          $display("FAIL rot_bwait: got %0d g%b want <=6 1",
                   cyc - last_b, bus.buy_grant);
        end
        last_b = cyc;
      end
      if (kind >= 0) begin
        total++;
        if (kind == prev_kind) begin
          bad++;
          $display("FAIL rot_repeat: got %0d twice want alt",
                   kind);
        end
        prev_kind = kind;
      end
      prev = bus.num_suns;
    end
    total++;
    if (64 - last_c > 6 || 64 - last_b > 6) begin
      bad++;
      $display("FAIL rot_starve: got c%0d b%0d want <=6",
               64 - last_c, 64 - last_b);
    end
    total++;
    if (drips < 6 || drips > 8) begin
      bad++;
      $display("FAIL rot_drips: got %0d want 6..8", drips);
    end
    bus.collect_req = 1'b0;
    bus.buy_req     = 1'b0;
    bus.enable      = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_enable;
    do_clear(1'b1);
    repeat (3) tick();
    bus.enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (bus.busy !== 1'b0 || bus.num_suns !== 16'd50) begin
        bad++;
        $display("FAIL en_hold: got b%b %0d want 0 50",
                 bus.busy, bus.num_suns);
      end
    end
    bus.enable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (bus.busy !== (k == 6) ||
          bus.num_suns !== ((k == 7) ? 16'd75 : 16'd50)) begin
        bad++;
        $display("FAIL en_resume%0d: got b%b %0d", k,
                 bus.busy, bus.num_suns);
      end
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic after_abort(input string tag);
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (bus.buy_ack !== 1'b0 ||
          bus.busy !== (k == 9) ||
          bus.num_suns !== ((k == 10) ? 16'd75 : 16'd50)) begin
        bad++;
        $display("FAIL %s_drip%0d: got a%b b%b %0d", tag, k,
                 bus.buy_ack, bus.busy, bus.num_suns);
      end
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_clear_abort;
    do_clear(1'b1);
    repeat (3) tick();
    bus.buy_cost = 16'd20;
    bus.buy_req  = 1'b1;
    tick();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL clr_busy: got %b want 1", bus.busy);
    end
    bus.buy_req    = 1'b0;
    bus.game_clear = 1'b1;
    tick();
    bus.game_clear = 1'b0;
    total++;
    if (bus.buy_ack !== 1'b0 || bus.busy !== 1'b0 ||
        bus.num_suns !== 16'd50) begin
      bad++;
      $display("FAIL clr_abort: got a%b b%b %0d want 0 0 50",
               bus.buy_ack, bus.busy, bus.num_suns);
    end
    after_abort("clr");
  endtask

  task automatic test_reset_abort;
    do_clear(1'b1);
    repeat (3) tick();
    bus.buy_cost = 16'd20;
    bus.buy_req  = 1'b1;
    tick();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL rsta_busy: got %b want 1", bus.busy);
    end
    #2;
    rst_n       = 1'b0;
    bus.buy_req = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.num_suns !== 16'd50) begin
      bad++;
      $display("FAIL rsta_async: got b%b %0d want 0 50",
               bus.busy, bus.num_suns);
    end
    tick();
    rst_n = 1'b1;
    total++;
    if (bus.buy_ack !== 1'b0 || bus.num_suns !== 16'd50) begin
      bad++;
      $display("FAIL rsta_abort: got a%b %0d want 0 50",
               bus.buy_ack, bus.num_suns);
    end
    after_abort("rsta");
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst_n           = 1'b0;
    bus.game_clear  = 1'b0;
    bus.enable      = 1'b0;
    bus.collect_req = 1'b0;
    bus.buy_req     = 1'b0;
    bus.buy_cost    = 16'd0;
    test_reset();
    test_collect();
    test_buy();
    test_saturate();
    test_rotation();
    test_enable();
    test_clear_abort();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
